ip_bus_log_writer: RTL and testbench
====================================

# ip_bus_log_writer

Capture front end of the bus logger cartridge: samples MSX bus events and packs each into a 32-bit log word. Words are buffered in a 4-entry FIFO and written sequentially into the 4K×32 log RAM over its valid/ready/write bus. The RAM bus is shared with a host read port; the host is granted only in cycles with no pending log write. The RAM read data path goes directly from the RAM to the host and does not pass through this block.

## Interface
- WRAP_MODE, 0: 0 = stop when 4096 words are logged; 1 = ring buffer, overwrite oldest.
- reset_n  in  1  active-low reset, synchronous to clk (one clock; reset is synchronous and active-low).
- clk  in  1  system clock.
- log_enable  in  1  level; 1 = capture events.
- log_clear  in  1  single-cycle pulse; rewind pointer, clear count and flags.
- ev_valid  in  1  single-cycle strobe, one MSX bus event.
- ev_write  in  1  1 = write cycle, 0 = read cycle (qualified by ev_valid).
- ev_io  in  1  1 = I/O space, 0 = memory (qualified by ev_valid).
- ev_address  in  16  MSX address.
- ev_data  in  8  MSX data byte.
- host_valid  in  1  host RAM read request.
- host_address  in  12  host read address.
- host_ready  out  1  host request issued to RAM this cycle.
- bus_address  out  12  RAM address.
- bus_valid  out  1  RAM request.
- bus_ready  in  1  RAM accepts request.
- bus_write  out  1  1 = log write, 0 = host read.
- bus_wdata  out  32  log word.
- log_count  out  13  words written, 0..4096.
- log_full  out  1  stop mode: 4096 words logged.
- log_wrapped  out  1  sticky; ring buffer has wrapped at least once.
- log_overflow  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- Log word: [31] ev_write, [30] ev_io, [29:24] delta, [23:8] ev_address, [7:0] ev_data.
- delta: 6-bit counter of clocks since the previous captured event. It increments every clk, saturates at 63, and is loaded with 0 on each captured event. The value written is the counter before that reload. Reset and log_clear set it to 63.
- States:
  - IDLE: log_enable=0.
  - RUN: log_enable=1, not full.
  - FULL: stop mode with 4096 words logged.
- Transitions:
  - IDLE→RUN when log_enable=1.
  - RUN→IDLE when log_enable=0.
  - RUN→FULL when the write that brings log_count to 4096 completes.
  - FULL→IDLE only on log_clear.
- Capture: event accepted in RUN when ev_valid=1 and the FIFO is not full. Otherwise:
  - In RUN with the FIFO full: dropped, and log_overflow is set.
  - In IDLE or FULL: dropped silently.
- FIFO: 4 entries. Push and pop in the same cycle are legal; with the FIFO full, a simultaneous pop frees the slot and the event is accepted.
- Drain: head of the FIFO is presented as bus_valid=1, bus_write=1, bus_address=wptr. It is held stable until bus_ready=1.
  - On acceptance: wptr increments and wraps 4095→0; log_count increments and saturates at 4096.
  - In ring mode, the write at wptr=4095 sets log_wrapped.
  - The FIFO continues draining after log_enable falls. Stop mode never pushes beyond 4096 entries.
- Host arbitration: host_ready = host_valid & ~fifo_nonempty & bus_ready (combinational). When granted: bus_valid=1, bus_write=0, bus_address=host_address.
- log_clear (any state): the FIFO is emptied; wptr, log_count, log_full, log_wrapped and log_overflow are set to 0; state goes to IDLE. If log_enable=1, state re-enters RUN the next cycle. RAM contents are untouched.

## Timing
- Reset values: bus_valid 0, bus_write 0, bus_address 0, bus_wdata 0, host_ready 0, log_count 0, log_full 0, log_wrapped 0, log_overflow 0. The FIFO is empty and the state is IDLE.
- ev_valid sampled at edge N → the word is in the FIFO after N. With the FIFO otherwise empty, bus_valid=1 in cycle N→N+1, and the RAM write and log_count update take effect at edge N+1.
- Sustained rate: 1 word/clk with bus_ready=1.
- Back-to-back ev_valid: each event is captured with delta=0 for the second and later events.
- log_full rises at the same edge at which log_count becomes 4096.
- Simultaneous log_clear and ev_valid: clear wins, and the event is dropped without setting log_overflow.
- Simultaneous log_clear and bus acceptance: the write completes in RAM, but counters reflect the clear (0).
- Reset mid-drain: the FIFO is discarded and all outputs return to their reset values at the next edge.

## Test plan
- Single event: reset, log_enable=1, 10 idle cycles, then ev_valid with write=1, io=0, addr=0x4000, data=0xA5 → one cycle later bus_valid=1, bus_write=1, bus_address=0, bus_wdata=0xBF4000A5 (delta saturated at 63); log_count=1.
- Burst: 6 events on consecutive clocks with bus_ready=0 for 8 cycles → 4 events are buffered, events 5–6 are dropped, log_overflow=1; after bus_ready=1, 4 writes to addresses 0..3 with delta=0 for entries 2–4.
- Stop mode: 4097 events → log_count=4096, log_full=1, the last event is never written, log_overflow=0; log_clear → all zero, the next event is written to address 0.
- Ring mode (WRAP_MODE=1): 4098 events → the writes to addresses 0 and 1 are overwritten by events 4097 and 4098; log_wrapped=1, log_count=4096, log_full=0.
- Arbitration: host_valid=1 with addr=0x123 while 2 words are queued → host_ready=0 for 2 cycles, then host_ready=1, bus_write=0, bus_address=0x123.
- Edge collisions: log_clear together with ev_valid → no FIFO push, log_count=0. Reset asserted with 3 words queued → no further bus_valid, and all outputs are at their reset values.

Source files
------------

// File: rtl/ip_bus_log_writer.sv
// ip_bus_log_writer
// Capture front end of the bus logger: packs MSX bus events into 32-bit log words, buffers them
// in a 4-entry FIFO and writes them sequentially into a 4Kx32 log RAM. The RAM request bus is
// shared with a host read port that is granted only when no log write is pending.
//
// Ports:
//   clk, reset_n                 system clock, synchronous active-low reset
//   log_enable, log_clear        capture enable level, single-cycle clear pulse
//   ev_valid/ev_write/ev_io      MSX bus event strobe and its qualifiers
//   ev_address, ev_data          MSX address and data byte
//   host_valid, host_address     host RAM read request
//   host_ready                   host request issued to the RAM this cycle
//   bus_valid/bus_ready          RAM request handshake
//   bus_write, bus_address       1 = log write, 0 = host read; RAM word address
//   bus_wdata                    log word
//   log_count                    words written, 0..4096
//   log_full, log_wrapped        stop-mode full flag, ring-mode wrapped (sticky)
//   log_overflow                 sticky; an event was dropped on a full FIFO
module ip_bus_log_writer #(
  parameter int unsigned WRAP_MODE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        log_enable,
  input  logic        log_clear,
  input  logic        ev_valid,
  input  logic        ev_write,
  input  logic        ev_io,
  input  logic [15:0] ev_address,
  input  logic [7:0]  ev_data,
  input  logic        host_valid,
  input  logic [11:0] host_address,
  output logic        host_ready,
  output logic [11:0] bus_address,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  output logic [12:0] log_count,
  output logic        log_full,
  output logic        log_wrapped,
  output logic        log_overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

  state_e      state_q;
  logic [31:0] fifo_q [4];
  logic [1:0]  rd_ptr_q, wr_ptr_q;
  logic [2:0]  fifo_cnt_q;
  logic [5:0]  delta_q;
  logic [11:0] wptr_q;
  logic [12:0] log_count_q;
  logic        log_wrapped_q, log_overflow_q;

  logic        fifo_nonempty, fifo_full, pop, push, room, ev_try, drop_full, reach_full;
  logic [31:0] ev_word;

  always_comb begin
    fifo_nonempty = (fifo_cnt_q != 3'd0);
    fifo_full     = (fifo_cnt_q == 3'd4);
    pop           = fifo_nonempty & bus_ready;
    // Stop mode counts words already queued so it never pushes past 4096 in total.
    room          = (WRAP_MODE != 0) || ((log_count_q + {10'd0, fifo_cnt_q}) < 13'd4096);
    ev_try        = (state_q == StRun) & ev_valid & ~log_clear;
    push          = ev_try & (~fifo_full | pop) & room;
    drop_full     = ev_try & fifo_full & ~pop;
    reach_full    = (WRAP_MODE == 0) && pop && (log_count_q == 13'd4095);
    ev_word       = {ev_write, ev_io, delta_q, ev_address, ev_data};
  end

  always_comb begin
    host_ready   = host_valid & ~fifo_nonempty & bus_ready;
    bus_valid    = fifo_nonempty | host_valid;
    bus_write    = fifo_nonempty;
    bus_address  = wptr_q;
    if (!fifo_nonempty && host_valid) bus_address = host_address;
    bus_wdata    = fifo_nonempty ? fifo_q[rd_ptr_q] : 32'd0;
    log_count    = log_count_q;
    log_full     = (state_q == StFull);
    log_wrapped  = log_wrapped_q;
    log_overflow = log_overflow_q;
  end

  // Storage needs no reset: the empty FIFO gates bus_wdata to zero.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= ev_word;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || log_clear) begin
      state_q        <= StIdle;
      rd_ptr_q       <= 2'd0;
      wr_ptr_q       <= 2'd0;
      fifo_cnt_q     <= 3'd0;
      delta_q        <= 6'd63;
      wptr_q         <= 12'd0;
      log_count_q    <= 13'd0;
      log_wrapped_q  <= 1'b0;
      log_overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
        wptr_q   <= wptr_q + 12'd1;
        if (log_count_q != 13'd4096) log_count_q <= log_count_q + 13'd1;
        if ((WRAP_MODE != 0) && (wptr_q == 12'd4095)) log_wrapped_q <= 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_q + {2'd0, push} - {2'd0, pop};

      // Clocks since the last captured event, saturating.
      if (push)                  delta_q <= 6'd0;
      else if (delta_q != 6'd63) delta_q <= delta_q + 6'd1;

      if (drop_full) log_overflow_q <= 1'b1;

      if (reach_full) begin
        state_q <= StFull;
      end else begin
        unique case (state_q)
          StIdle:  if (log_enable) state_q <= StRun;
          StRun:   if (!log_enable) state_q <= StIdle;
          StFull:  state_q <= StFull;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ip_bus_log_writer.sv
module tb_ip_bus_log_writer;

  logic        clk = 1'b0;
  logic        reset_n, log_enable, log_clear, ev_valid, ev_write, ev_io;
  logic [15:0] ev_address;
  logic [7:0]  ev_data;
  logic        host_valid, bus_ready;
  logic [11:0] host_address;

  logic        hr [2], bv [2], bw [2], lf [2], lw [2], lo [2];
  logic [11:0] ba [2];
  logic [31:0] wd [2];
  logic [12:0] lc [2];

  always #5 clk = ~clk;

  ip_bus_log_writer #(.WRAP_MODE(0)) u_stop (
    .clk(clk), .reset_n(reset_n), .log_enable(log_enable), .log_clear(log_clear),
    .ev_valid(ev_valid), .ev_write(ev_write), .ev_io(ev_io), .ev_address(ev_address),
    .ev_data(ev_data), .host_valid(host_valid), .host_address(host_address),
    .host_ready(hr[0]), .bus_address(ba[0]), .bus_valid(bv[0]), .bus_ready(bus_ready),
    .bus_write(bw[0]), .bus_wdata(wd[0]), .log_count(lc[0]), .log_full(lf[0]),
    .log_wrapped(lw[0]), .log_overflow(lo[0])
  );

  ip_bus_log_writer #(.WRAP_MODE(1)) u_ring (
    .clk(clk), .reset_n(reset_n), .log_enable(log_enable), .log_clear(log_clear),
    .ev_valid(ev_valid), .ev_write(ev_write), .ev_io(ev_io), .ev_address(ev_address),
    .ev_data(ev_data), .host_valid(host_valid), .host_address(host_address),
    .host_ready(hr[1]), .bus_address(ba[1]), .bus_valid(bv[1]), .bus_ready(bus_ready),
    .bus_write(bw[1]), .bus_wdata(wd[1]), .log_count(lc[1]), .log_full(lf[1]),
    .log_wrapped(lw[1]), .log_overflow(lo[1])
  );

  // Log RAMs written by each DUT.
  logic [31:0] ram [2][4096];
  always @(posedge clk) if (bv[0] && bw[0] && bus_ready) ram[0][ba[0]] <= wd[0];
  always @(posedge clk) if (bv[1] && bw[1] && bus_ready) ram[1][ba[1]] <= wd[1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model, index 0 = stop mode, 1 = ring mode.
  // st: 0 idle, 1 capturing, 2 full. fq holds queued words, head at index 0.
  int          st [2], fc [2], wp [2], cnt [2], dl [2];
  bit          wr [2], ov [2];
  logic [31:0] fq [2][4];
  logic [31:0] em [2][4096];

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit pop, tryev, push, room, reach, dropf;
      logic [31:0] word;
      pop = (fc[m] > 0) && bus_ready;
      if (!reset_n) begin
        if (pop) em[m][wp[m]] = fq[m][0];
        st[m] = 0; fc[m] = 0; wp[m] = 0; cnt[m] = 0; wr[m] = 0; ov[m] = 0; dl[m] = 63;
      end else begin
        word  = {ev_write, ev_io, 6'(dl[m]), ev_address, ev_data};
        tryev = (st[m] == 1) && ev_valid && !log_clear;
        room  = (m == 1) || (cnt[m] + fc[m] < 4096);
        push  = tryev && (fc[m] < 4 || pop) && room;
        dropf = tryev && fc[m] == 4 && !pop;
        reach = 0;
        if (pop) begin
          em[m][wp[m]] = fq[m][0];
          if (m == 1 && wp[m] == 4095) wr[m] = 1;
          wp[m] = (wp[m] + 1) % 4096;
          if (cnt[m] < 4096) cnt[m]++;
          reach = (m == 0) && (cnt[m] == 4096);
          for (int i = 0; i < 3; i++) fq[m][i] = fq[m][i + 1];
          fc[m]--;
        end
        if (dropf) ov[m] = 1;
        if (push) begin
          fq[m][fc[m]] = word;
          fc[m]++;
          dl[m] = 0;
        end else if (dl[m] < 63) dl[m]++;
        if (log_clear) begin
          fc[m] = 0; wp[m] = 0; cnt[m] = 0; wr[m] = 0; ov[m] = 0; dl[m] = 63; st[m] = 0;
        end else if (reach) st[m] = 2;
        else if (st[m] == 0 && log_enable) st[m] = 1;
        else if (st[m] == 1 && !log_enable) st[m] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      bit ne;
      ne = fc[m] > 0;
      chk($sformatf("m%0d bus_valid", m), 32'(bv[m]), 32'(ne || host_valid));
      chk($sformatf("m%0d bus_write", m), 32'(bw[m]), 32'(ne));
      chk($sformatf("m%0d host_ready", m), 32'(hr[m]), 32'(host_valid && !ne && bus_ready));
      chk($sformatf("m%0d log_count", m), 32'(lc[m]), 32'(cnt[m]));
      chk($sformatf("m%0d log_full", m), 32'(lf[m]), 32'(st[m] == 2));
      chk($sformatf("m%0d log_wrapped", m), 32'(lw[m]), 32'(wr[m]));
      chk($sformatf("m%0d log_overflow", m), 32'(lo[m]), 32'(ov[m]));
      if (ne) begin
        chk($sformatf("m%0d bus_address write", m), 32'(ba[m]), 32'(wp[m]));
        chk($sformatf("m%0d bus_wdata", m), wd[m], fq[m][0]);
      end else if (host_valid) begin
        chk($sformatf("m%0d bus_address host", m), 32'(ba[m]), 32'(host_address));
      end
    end
  endtask

  task automatic advance();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    #4;
    advance();
  endtask

  task automatic idle_inputs();
    log_clear = 0; ev_valid = 0; ev_write = 0; ev_io = 0; ev_address = 0; ev_data = 0;
    host_valid = 0; host_address = 0;
  endtask

  task automatic check_reset_values();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d reset bus_valid", m), 32'(bv[m]), 0);
      chk($sformatf("m%0d reset bus_write", m), 32'(bw[m]), 0);
      chk($sformatf("m%0d reset bus_address", m), 32'(ba[m]), 0);
      chk($sformatf("m%0d reset bus_wdata", m), wd[m], 0);
      chk($sformatf("m%0d reset host_ready", m), 32'(hr[m]), 0);
      chk($sformatf("m%0d reset log_count", m), 32'(lc[m]), 0);
      chk($sformatf("m%0d reset flags", m), 32'({lf[m], lw[m], lo[m]}), 0);
    end
  endtask

  typedef struct {
    logic clr, ev, w, io;
    logic [15:0] a;
    logic [7:0] d;
    logic rdy, hv;
    logic [11:0] ha;
    logic e_bv, e_bw;
    logic [11:0] e_ba;
    logic [31:0] e_wd;
    logic e_hr;
    logic [12:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic clr, logic ev, logic w, logic io, logic [15:0] a,
                              logic [7:0] d, logic rdy, logic hv, logic [11:0] ha,
                              logic e_bv, logic e_bw, logic [11:0] e_ba, logic [31:0] e_wd,
                              logic e_hr, logic [12:0] e_cnt);
    vec_t v;
    v.clr = clr; v.ev = ev; v.w = w; v.io = io; v.a = a; v.d = d; v.rdy = rdy; v.hv = hv;
    v.ha = ha; v.e_bv = e_bv; v.e_bw = e_bw; v.e_ba = e_ba; v.e_wd = e_wd; v.e_hr = e_hr;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  // Word expected for the k-th event of the long run: delta 63 for the first, 0 afterwards.
  function automatic logic [31:0] evw(int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {kk[0], kk[1], (k == 1) ? 6'd63 : 6'd0, kk, kk[7:0] ^ 8'h5A};
  endfunction

  vec_t tbl [13];

  initial begin
    tbl[0]  = mk(0, 1, 1, 0, 16'h4000, 8'hA5, 1, 0, 12'h000, 0, 0, 12'h000, 32'h0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 12'h000, 1, 1, 12'h000, 32'hBF4000A5, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 12'h000, 0, 0, 12'h000, 32'h0, 0, 1);
    tbl[3]  = mk(0, 1, 0, 1, 16'h0098, 8'h11, 0, 1, 12'h123, 1, 0, 12'h123, 32'h0, 0, 1);
    tbl[4]  = mk(0, 1, 1, 1, 16'hFFFF, 8'h00, 0, 1, 12'h123, 1, 1, 12'h001, 32'h42009811, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 12'h123, 1, 1, 12'h001, 32'h42009811, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 12'h123, 1, 1, 12'h002, 32'hC0FFFF00, 0, 2);
    tbl[7]  = mk(0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 12'h123, 1, 0, 12'h123, 32'h0, 1, 3);
    tbl[8]  = mk(1, 1, 1, 1, 16'h7777, 8'h77, 1, 0, 12'h000, 0, 0, 12'h000, 32'h0, 0, 3);
    tbl[9]  = mk(0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 12'h000, 0, 0, 12'h000, 32'h0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 16'h1234, 8'h56, 1, 0, 12'h000, 0, 0, 12'h000, 32'h0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 12'h000, 1, 1, 12'h000, 32'h3F123456, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 12'h000, 0, 0, 12'h000, 32'h0, 0, 1);

    // Reset
    idle_inputs();
    reset_n = 0; log_enable = 0; bus_ready = 1;
    for (int m = 0; m < 2; m++) begin
      st[m] = 0; fc[m] = 0; wp[m] = 0; cnt[m] = 0; wr[m] = 0; ov[m] = 0; dl[m] = 63;
    end
    @(posedge clk); #1;
    tick(); tick();
    #4 check_reset_values();
    advance();
    reset_n = 1; log_enable = 1;
    for (int i = 0; i < 11; i++) tick();

    // Single event, host arbitration, clear collision, write after clear
    foreach (tbl[i]) begin
      log_clear = tbl[i].clr; ev_valid = tbl[i].ev; ev_write = tbl[i].w; ev_io = tbl[i].io;
      ev_address = tbl[i].a; ev_data = tbl[i].d; bus_ready = tbl[i].rdy;
      host_valid = tbl[i].hv; host_address = tbl[i].ha;
      #4;
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("vec%0d m%0d bus_valid", i, m), 32'(bv[m]), 32'(tbl[i].e_bv));
        chk($sformatf("vec%0d m%0d host_ready", i, m), 32'(hr[m]), 32'(tbl[i].e_hr));
        chk($sformatf("vec%0d m%0d log_count", i, m), 32'(lc[m]), 32'(tbl[i].e_cnt));
        if (tbl[i].e_bv) begin
          chk($sformatf("vec%0d m%0d bus_write", i, m), 32'(bw[m]), 32'(tbl[i].e_bw));
          chk($sformatf("vec%0d m%0d bus_address", i, m), 32'(ba[m]), 32'(tbl[i].e_ba));
        end
        if (tbl[i].e_bw)
          chk($sformatf("vec%0d m%0d bus_wdata", i, m), wd[m], tbl[i].e_wd);
      end
      advance();
    end
    idle_inputs();

    // Burst of 6 events into a stalled RAM: 4 buffered, 2 dropped
    bus_ready = 0;
    for (int i = 0; i < 8; i++) begin
      ev_valid = (i < 6); ev_write = 1; ev_io = 0;
      ev_address = 16'hB000 + 16'(i); ev_data = 8'(i);
      tick();
    end
    ev_valid = 0; bus_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("burst m%0d overflow", m), 32'(lo[m]), 1);
      chk($sformatf("burst m%0d log_count", m), 32'(lc[m]), 5);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("burst m%0d entry%0d", m, i), {8'h0, ram[m][1 + i][23:0]},
            {8'h0, 16'hB000 + 16'(i), 8'(i)});
        if (i > 0) chk($sformatf("burst m%0d delta%0d", m, i), 32'(ram[m][1 + i][29:24]), 0);
      end
    end

    // Long run: stop mode fills, ring mode wraps
    log_clear = 1; tick(); log_clear = 0; tick(); tick();
    for (int k = 1; k <= 4098; k++) begin
      logic [15:0] kk;
      kk = 16'(k);
      ev_valid = 1; ev_write = kk[0]; ev_io = kk[1]; ev_address = kk;
      ev_data = kk[7:0] ^ 8'h5A;
      tick();
    end
    ev_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("stop log_count", 32'(lc[0]), 4096);
    chk("stop log_full", 32'(lf[0]), 1);
    chk("stop log_overflow", 32'(lo[0]), 0);
    chk("stop first word", ram[0][0], evw(1));
    chk("stop last word", ram[0][4095], evw(4096));
    chk("ring log_count", 32'(lc[1]), 4096);
    chk("ring log_full", 32'(lf[1]), 0);
    chk("ring log_wrapped", 32'(lw[1]), 1);
    chk("ring overwrite 0", ram[1][0], evw(4097));
    chk("ring overwrite 1", ram[1][1], evw(4098));
    chk("ring keep 2", ram[1][2], evw(3));

    // Clear out of FULL, next event lands at address 0
    log_clear = 1; tick(); log_clear = 0;
    #4 chk("clear log_full", 32'(lf[0]), 0);
    advance(); tick();
    ev_valid = 1; ev_write = 0; ev_io = 1; ev_address = 16'hCAFE; ev_data = 8'h3C;
    tick();
    ev_valid = 0; tick(); tick();
    chk("after clear word", ram[0][0], 32'h7FCAFE3C);
    chk("after clear count", 32'(lc[0]), 1);

    // Reset with 3 words queued
    bus_ready = 0;
    for (int i = 0; i < 4; i++) begin
      ev_valid = (i < 3); ev_address = 16'h9000 + 16'(i); tick();
    end
    ev_valid = 0; reset_n = 0; tick();
    reset_n = 1; log_enable = 0; bus_ready = 1;
    #4 check_reset_values();
    advance(); tick();
    #4 check_reset_values();
    advance();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 699) != 0);
      log_enable = ($urandom_range(0, 15) != 0);
      log_clear = ($urandom_range(0, 149) == 0);
      ev_valid = $urandom_range(0, 1) == 1;
      ev_write = $urandom_range(0, 1) == 1;
      ev_io = $urandom_range(0, 1) == 1;
      ev_address = 16'($urandom);
      ev_data = 8'($urandom);
      bus_ready = ($urandom_range(0, 3) != 0);
      host_valid = ($urandom_range(0, 2) == 0);
      host_address = 12'($urandom);
      tick();
    end
    idle_inputs(); reset_n = 1; bus_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    for (int m = 0; m < 2; m++) begin
      int bad;
      bad = 0;
      for (int a = 0; a < 4096; a++) if (ram[m][a] !== em[m][a]) bad++;
      chk($sformatf("m%0d ram image differing words", m), 32'(bad), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
